// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between CPU, external master, data memory and the dmem port arbiter.
// slave = arbiter view; master = environment (CPU, ext master, dmem) view.
interface dmem_port_arbiter_if;
    logic        cpu_cs;
    logic        cpu_w;
    logic [1:0]  cpu_w_cs;
    logic [1:0]  cpu_r_cs;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        ext_req;
    logic        ext_w;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;

    logic        dm_cs;
    logic        dm_w;
    logic [1:0]  dm_w_cs;
    logic [1:0]  dm_r_cs;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_cs, cpu_w, cpu_w_cs, cpu_r_cs, cpu_addr, cpu_wdata,
        input  ext_req, ext_w, ext_addr, ext_wdata,
        input  dm_rdata,
        output cpu_rdata, cpu_stall,
        output ext_gnt, ext_rvalid, ext_rdata,
        output dm_cs, dm_w, dm_w_cs, dm_r_cs, dm_addr, dm_wdata
    );

    modport master (
        output cpu_cs, cpu_w, cpu_w_cs, cpu_r_cs, cpu_addr, cpu_wdata,
        output ext_req, ext_w, ext_addr, ext_wdata,
        output dm_rdata,
        input  cpu_rdata, cpu_stall,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  dm_cs, dm_w, dm_w_cs, dm_r_cs, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the CPU (default owner) and an external master.
// Optional starvation guard (CPU stall after MAX_WAIT busy cycles): define ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 16,
    parameter logic [1:0]  WORD_CS  = 2'b00
) (
    input  logic                clk_in,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

    state_t      r_state, w_state_nxt;
    logic        w_gnt;
    logic        r_ext_rvalid;
    logic [31:0] r_ext_rdata;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic             w_stall;
`else
    logic w_unused;
    assign w_unused = ^{bus.ext_addr[1:0], MAX_WAIT[0]};
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_IDLE;
`ifdef ARB_STARVE_GUARD_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef ARB_STARVE_GUARD_EN
            r_wait_cnt <= w_wait_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        w_stall        = 1'b0;
        w_wait_cnt_nxt = r_wait_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.ext_req) begin
                    if (!bus.cpu_cs) begin
                        w_gnt = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
`ifdef ARB_STARVE_GUARD_EN
                        w_wait_cnt_nxt = CNT_ONE;
`endif
                    end
                end
            end
            S_WAIT: begin
                // A dropped request is tolerated: return to IDLE without serving it.
                if (!bus.ext_req || !bus.cpu_cs) begin
                    w_gnt       = bus.ext_req;
                    w_state_nxt = S_IDLE;
`ifdef ARB_STARVE_GUARD_EN
                    w_wait_cnt_nxt = '0;
`endif
                end else begin
`ifdef ARB_STARVE_GUARD_EN
                    if (r_wait_cnt == CNT_LAST) w_state_nxt    = S_FORCE;
                    else                        w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
`endif
                end
            end
            S_FORCE: begin
                w_gnt       = 1'b1;
                w_state_nxt = S_IDLE;
`ifdef ARB_STARVE_GUARD_EN
                w_stall        = 1'b1;
                w_wait_cnt_nxt = '0;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            r_ext_rvalid <= w_gnt & ~bus.ext_w;
            if (w_gnt && !bus.ext_w) r_ext_rdata <= bus.dm_rdata;
        end
    end

    // Port mux: ext owns the port only in a grant cycle; the CPU request is dropped then.
    assign bus.dm_cs    = w_gnt | bus.cpu_cs;
    assign bus.dm_w     = w_gnt ? bus.ext_w : (bus.cpu_cs & bus.cpu_w);
    assign bus.dm_w_cs  = w_gnt ? WORD_CS : bus.cpu_w_cs;
    assign bus.dm_r_cs  = w_gnt ? WORD_CS : bus.cpu_r_cs;
    assign bus.dm_addr  = w_gnt ? {bus.ext_addr[31:2], 2'b00} : bus.cpu_addr;
    assign bus.dm_wdata = w_gnt ? bus.ext_wdata : bus.cpu_wdata;

    assign bus.cpu_rdata  = bus.dm_rdata;
    assign bus.ext_gnt    = w_gnt;
    assign bus.ext_rvalid = r_ext_rvalid;
    assign bus.ext_rdata  = r_ext_rdata;
`ifdef ARB_STARVE_GUARD_EN
    assign bus.cpu_stall  = w_stall;
`else
    assign bus.cpu_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus queues expected grants/read data, a negedge monitor checks them.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.MAX_WAIT(16), .WORD_CS(2'b00)) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    // Simple data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:63];
    assign bus.dm_rdata = mem[bus.dm_addr[7:2]];
    always @(posedge clk) if (bus.dm_cs && bus.dm_w) mem[bus.dm_addr[7:2]] <= bus.dm_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        stall;
        logic        w;
        logic [31:0] addr;
    } gnt_t;

    gnt_t        q_gnt [$];
    logic [31:0] q_rd  [$];
    logic [31:0] q_cpu [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_stall = 1'b0;
    gnt_t        g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ext_gnt) begin
            if (q_gnt.size() == 0) chk("spurious_gnt", {31'd0, bus.ext_gnt}, 32'd0);
            else begin
                g = q_gnt.pop_front();
                chk("gnt_cycle",  cyc, g.cyc);
                chk("gnt_stall",  {31'd0, bus.cpu_stall}, {31'd0, g.stall});
                chk("gnt_dm_cs",  {31'd0, bus.dm_cs}, 32'd1);
                chk("gnt_dm_w",   {31'd0, bus.dm_w}, {31'd0, g.w});
                chk("gnt_dm_addr", bus.dm_addr, g.addr);
                chk("gnt_width",  {28'd0, bus.dm_w_cs, bus.dm_r_cs}, 32'd0);
            end
        end else if (bus.cpu_stall) begin
            chk("stall_without_gnt", {31'd0, bus.cpu_stall}, 32'd0);
        end
        if (bus.cpu_stall) chk("stall_consecutive", {31'd0, prev_stall}, 32'd0);
        prev_stall <= bus.cpu_stall;
        if (bus.ext_rvalid) begin
            if (q_rd.size() == 0) chk("spurious_rvalid", {31'd0, bus.ext_rvalid}, 32'd0);
            else chk("ext_rdata", bus.ext_rdata, q_rd.pop_front());
        end
        if (bus.cpu_cs && !bus.cpu_w && !bus.cpu_stall && !bus.ext_gnt) begin
            if (q_cpu.size() != 0) chk("cpu_rdata", bus.cpu_rdata, q_cpu.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic cs, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_cs = cs; bus.cpu_w = w; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic set_ext(input logic req, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.ext_req = req; bus.ext_w = w; bus.ext_addr = a; bus.ext_wdata = d;
    endtask

    task automatic exp_gnt(input int c, input logic s, input logic w, input logic [31:0] a);
        gnt_t e;
        e.cyc = c; e.stall = s; e.w = w; e.addr = a;
        q_gnt.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},    {31'd0, bus.ext_gnt},    32'd0);
        chk({tag, "_stall"},  {31'd0, bus.cpu_stall},  32'd0);
        chk({tag, "_rvalid"}, {31'd0, bus.ext_rvalid}, 32'd0);
        chk({tag, "_rdata"},  bus.ext_rdata,           32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_w_cs = 2'b10;
        bus.cpu_r_cs = 2'b01;
        set_cpu(0, 0, 0, 0);
        set_ext(0, 0, 0, 0);
        step(); step();
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // CPU-only write then read back.
        set_cpu(1, 1, 32'h10, 32'hDEADBEEF);
        step();
        set_cpu(1, 0, 32'h10, 0); q_cpu.push_back(32'hDEADBEEF);
        step();
        set_cpu(0, 0, 0, 0);

        // Ext read in a CPU-idle cycle: grant same cycle, data next cycle.
        set_ext(1, 0, 32'h10, 0);
        exp_gnt(cyc, 0, 0, 32'h10); q_rd.push_back(32'hDEADBEEF);
        step();
        set_ext(0, 0, 0, 0);
        step();

        // Conflict: CPU busy 3 cycles, ext write waits for first idle cycle.
        set_ext(1, 1, 32'h20, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            set_cpu(1, 0, 32'h10, 0); q_cpu.push_back(32'hDEADBEEF);
            step();
        end
        set_cpu(0, 0, 0, 0);
        exp_gnt(cyc, 0, 1, 32'h20);
        step();
        // Misaligned ext address is word-aligned; back-to-back grants in idle cycles.
        set_ext(1, 0, 32'h23, 0);
        exp_gnt(cyc, 0, 0, 32'h20); q_rd.push_back(32'h12345678);
        step();
        set_ext(1, 0, 32'h10, 0);
        exp_gnt(cyc, 0, 0, 32'h10); q_rd.push_back(32'hDEADBEEF);
        step();
        set_ext(0, 0, 0, 0);
        set_cpu(1, 0, 32'h20, 0); q_cpu.push_back(32'h12345678);
        step();
        set_cpu(0, 0, 0, 0);
        step();

`ifdef ARB_STARVE_GUARD_EN
        // Starvation: forced slot 16 cycles after the request, exactly once.
        set_cpu(1, 1, 32'h30, 32'hA5A5A5A5);
        set_ext(1, 0, 32'h10, 0);
        exp_gnt(cyc + 16, 1, 0, 32'h10); q_rd.push_back(32'hDEADBEEF);
        for (int i = 0; i < 16; i++) step();
        step();
        set_ext(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        set_cpu(0, 0, 0, 0);
        step();

        // Reset sampled during the stall cycle: read data never delivered.
        set_cpu(1, 1, 32'h30, 32'hA5A5A5A5);
        set_ext(1, 0, 32'h10, 0);
        exp_gnt(cyc + 16, 1, 0, 32'h10);
        for (int i = 0; i < 16; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_ext(0, 0, 0, 0);
        @(negedge clk);
        chk_reset_outputs("force_reset");
        step();
        set_cpu(0, 0, 0, 0);
        set_ext(1, 0, 32'h20, 0);
        exp_gnt(cyc, 0, 0, 32'h20); q_rd.push_back(32'h12345678);
        step();
        set_ext(0, 0, 0, 0);
        step();
`else
        // No guard: 100 busy cycles, no grant and no stall until the CPU goes idle.
        set_cpu(1, 1, 32'h30, 32'hA5A5A5A5);
        set_ext(1, 1, 32'h34, 32'h5A5A0000);
        for (int i = 0; i < 100; i++) step();
        set_cpu(0, 0, 0, 0);
        exp_gnt(cyc, 0, 1, 32'h34);
        step();
        set_ext(0, 0, 0, 0);
        set_cpu(1, 0, 32'h34, 0); q_cpu.push_back(32'h5A5A0000);
        step();
        set_cpu(0, 0, 0, 0);
        step();
`endif

        step(); step();
        chk("pending_grants",   q_gnt.size(), 32'd0);
        chk("pending_ext_data", q_rd.size(),  32'd0);
        chk("pending_cpu_data", q_cpu.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
